// File: rtl/axi_llc_write_unit_queued_if.sv
// Shared payload types and the bundled handshake interface of the queued LLC write unit.
package axi_llc_write_unit_queued_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned IdW   = 4;
    localparam int unsigned DataW = 64;
    localparam int unsigned StrbW = DataW / 8;
    localparam int unsigned IdxW  = 8;
    localparam int unsigned BoW   = 3;
    localparam int unsigned WayW  = 3;
    localparam int unsigned LenW  = 8;

    typedef struct packed {
        int unsigned IndexLength;
        int unsigned BlockOffsetLength;
        int unsigned ByteOffsetLength;
    } llc_cfg_t;

    typedef struct packed {
        int unsigned IdWidthFull;
        int unsigned AddrWidthFull;
        int unsigned DataWidthFull;
    } llc_axi_cfg_t;

    localparam llc_cfg_t DefaultCfg = '{IndexLength: IdxW, BlockOffsetLength: BoW,
                                        ByteOffsetLength: 3};
    localparam llc_axi_cfg_t DefaultAxiCfg = '{IdWidthFull: IdW, AddrWidthFull: AddrW,
                                               DataWidthFull: DataW};

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] WChanUnit  = 2'd2;

    typedef struct packed {
        logic [IdW-1:0]   a_x_id;
        logic [AddrW-1:0] a_x_addr;
        logic [LenW-1:0]  a_x_len;
        logic [2:0]       a_x_size;
        logic [1:0]       a_x_burst;
        logic [1:0]       x_resp;
        logic             x_last;
        logic [WayW-1:0]  way_ind;
    } desc_t;

    typedef struct packed {
        logic [1:0]       cache_unit;
        logic [WayW-1:0]  way_ind;
        logic [IdxW-1:0]  line_addr;
        logic [BoW-1:0]   blk_offset;
        logic             we;
        logic [DataW-1:0] data;
        logic [StrbW-1:0] strb;
    } way_inp_t;

    typedef struct packed {
        logic [IdxW-1:0] index;
        logic [WayW-1:0] way_ind;
    } lock_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic [StrbW-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
    } b_chan_t;

endpackage

interface axi_llc_write_unit_queued_if #(
    parameter type desc_t    = axi_llc_write_unit_queued_pkg::desc_t,
    parameter type way_inp_t = axi_llc_write_unit_queued_pkg::way_inp_t,
    parameter type lock_t    = axi_llc_write_unit_queued_pkg::lock_t,
    parameter type w_chan_t  = axi_llc_write_unit_queued_pkg::w_chan_t,
    parameter type b_chan_t  = axi_llc_write_unit_queued_pkg::b_chan_t
);
    desc_t    desc_i;
    logic     desc_valid_i;
    logic     desc_ready_o;
    w_chan_t  w_chan_slv_i;
    logic     w_chan_valid_i;
    logic     w_chan_ready_o;
    b_chan_t  b_chan_slv_o;
    logic     b_chan_valid_o;
    logic     b_chan_ready_i;
    way_inp_t way_inp_o;
    logic     way_inp_valid_o;
    logic     way_inp_ready_i;
    lock_t    w_unlock_o;
    logic     w_unlock_req_o;
    logic     w_unlock_gnt_i;

    modport slave (
        input  desc_i, desc_valid_i, w_chan_slv_i, w_chan_valid_i, b_chan_ready_i,
               way_inp_ready_i, w_unlock_gnt_i,
        output desc_ready_o, w_chan_ready_o, b_chan_slv_o, b_chan_valid_o,
               way_inp_o, way_inp_valid_o, w_unlock_o, w_unlock_req_o
    );

    modport master (
        output desc_i, desc_valid_i, w_chan_slv_i, w_chan_valid_i, b_chan_ready_i,
               way_inp_ready_i, w_unlock_gnt_i,
        input  desc_ready_o, w_chan_ready_o, b_chan_slv_o, b_chan_valid_o,
               way_inp_o, way_inp_valid_o, w_unlock_o, w_unlock_req_o
    );
endinterface

// File: rtl/axi_llc_write_unit_queued.sv
// LLC write unit: queues descriptors, W beats and B responses; walks each burst into data-way writes.
module axi_llc_wuq_fifo #(
    parameter int unsigned Depth  = 2,
    parameter type         data_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push_i,
    input  data_t data_i,
    output logic  full_o,
    input  logic  pop_i,
    output data_t data_o,
    output logic  empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    data_t            mem_q [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= next_ptr(wr_q);
            if (do_pop)  rd_q <= next_ptr(rd_q);
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage array, written on accepted push only.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

module axi_llc_write_unit_queued
    import axi_llc_write_unit_queued_pkg::llc_cfg_t, axi_llc_write_unit_queued_pkg::llc_axi_cfg_t,
           axi_llc_write_unit_queued_pkg::DefaultCfg, axi_llc_write_unit_queued_pkg::DefaultAxiCfg,
           axi_llc_write_unit_queued_pkg::AddrW, axi_llc_write_unit_queued_pkg::IdW,
           axi_llc_write_unit_queued_pkg::DataW, axi_llc_write_unit_queued_pkg::IdxW,
           axi_llc_write_unit_queued_pkg::BoW, axi_llc_write_unit_queued_pkg::LenW,
           axi_llc_write_unit_queued_pkg::BurstIncr, axi_llc_write_unit_queued_pkg::BurstWrap,
           axi_llc_write_unit_queued_pkg::RespSlvErr, axi_llc_write_unit_queued_pkg::WChanUnit;
#(
    parameter llc_cfg_t     Cfg       = DefaultCfg,
    parameter llc_axi_cfg_t AxiCfg    = DefaultAxiCfg,
    parameter type          desc_t    = axi_llc_write_unit_queued_pkg::desc_t,
    parameter type          way_inp_t = axi_llc_write_unit_queued_pkg::way_inp_t,
    parameter type          lock_t    = axi_llc_write_unit_queued_pkg::lock_t,
    parameter type          w_chan_t  = axi_llc_write_unit_queued_pkg::w_chan_t,
    parameter type          b_chan_t  = axi_llc_write_unit_queued_pkg::b_chan_t,
    parameter int unsigned  WDepth    = 4,
    parameter int unsigned  DescDepth = 2,
    parameter int unsigned  BDepth    = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              test_i,
    axi_llc_write_unit_queued_if.slave        bus,
    output logic                              busy_o
);
    localparam int unsigned ByteOff = Cfg.ByteOffsetLength;
    localparam int unsigned LineOff = Cfg.ByteOffsetLength + Cfg.BlockOffsetLength;

    // Reject configurations the fixed payload widths cannot carry.
    if (AxiCfg.DataWidthFull != DataW || AxiCfg.AddrWidthFull != AddrW ||
        AxiCfg.IdWidthFull != IdW || Cfg.IndexLength != IdxW ||
        Cfg.BlockOffsetLength != BoW || WDepth < 1 || DescDepth < 1 || BDepth < 1) begin : g_bad_cfg
        $error("axi_llc_write_unit_queued: unsupported parameter set");
    end

    typedef enum logic [1:0] {Idle, Write, Drop} state_e;

    state_e           state_q, state_d;
    desc_t            desc_q, desc_d;
    logic [AddrW-1:0] mask_q, mask_d;

    desc_t   desc_head;
    w_chan_t w_head;
    b_chan_t b_entry;
    logic    desc_full, desc_empty, desc_pop;
    logic    w_full, w_empty, w_pop;
    logic    b_full, b_empty, b_push;
    logic    way_valid, consume, load, last_beat, unlock_req;
    logic    unused_test;

    assign unused_test = test_i;

    axi_llc_wuq_fifo #(.Depth(DescDepth), .data_t(desc_t)) i_desc_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(bus.desc_valid_i), .data_i(bus.desc_i),
        .full_o(desc_full), .pop_i(desc_pop), .data_o(desc_head), .empty_o(desc_empty));

    axi_llc_wuq_fifo #(.Depth(WDepth), .data_t(w_chan_t)) i_w_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(bus.w_chan_valid_i), .data_i(bus.w_chan_slv_i),
        .full_o(w_full), .pop_i(w_pop), .data_o(w_head), .empty_o(w_empty));

    axi_llc_wuq_fifo #(.Depth(BDepth), .data_t(b_chan_t)) i_b_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(b_push), .data_i(b_entry),
        .full_o(b_full), .pop_i(bus.b_chan_ready_i), .data_o(bus.b_chan_slv_o), .empty_o(b_empty));

    function automatic logic [AddrW-1:0] num_bytes(input logic [2:0] size);
        return AddrW'(1) << size;
    endfunction

    // Address of the following beat for FIXED / INCR / WRAP bursts.
    function automatic logic [AddrW-1:0] next_addr(input desc_t d, input logic [AddrW-1:0] mask);
        logic [AddrW-1:0] nb, sum;
        nb  = num_bytes(d.a_x_size);
        sum = d.a_x_addr + nb;
        case (d.a_x_burst)
            BurstIncr: return sum & ~(nb - AddrW'(1));
            BurstWrap: return (d.a_x_addr & ~mask) | (sum & mask);
            default:   return d.a_x_addr;
        endcase
    endfunction

    // Interface outputs that follow directly from queue state and the active descriptor.
    always_comb begin
        bus.desc_ready_o           = ~desc_full;
        bus.w_chan_ready_o         = ~w_full;
        bus.b_chan_valid_o         = ~b_empty;
        bus.way_inp_valid_o        = way_valid;
        bus.w_unlock_req_o         = unlock_req;
        bus.way_inp_o.cache_unit   = WChanUnit;
        bus.way_inp_o.way_ind      = desc_q.way_ind;
        bus.way_inp_o.line_addr    = IdxW'(desc_q.a_x_addr >> LineOff);
        bus.way_inp_o.blk_offset   = BoW'(desc_q.a_x_addr >> ByteOff);
        bus.way_inp_o.we           = 1'b1;
        bus.way_inp_o.data         = w_head.data;
        bus.way_inp_o.strb         = w_head.strb;
        bus.w_unlock_o.index       = IdxW'(desc_q.a_x_addr >> LineOff);
        bus.w_unlock_o.way_ind     = desc_q.way_ind;
        b_entry.id                 = desc_q.a_x_id;
        b_entry.resp               = desc_q.x_resp;
        busy_o = (state_q != Idle) | ~desc_empty | ~w_empty | ~b_empty;
    end

    // Next-state: descriptor load, beat consumption, address/length stepping.
    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        mask_d     = mask_q;
        desc_pop   = 1'b0;
        w_pop      = 1'b0;
        b_push     = 1'b0;
        way_valid  = 1'b0;
        unlock_req = 1'b0;
        consume    = 1'b0;
        load       = 1'b0;
        last_beat  = (desc_q.a_x_len == '0);

        case (state_q)
            Idle: load = ~desc_empty;
            Write, Drop: begin
                if (bus.w_unlock_gnt_i && !w_empty && !(last_beat && desc_q.x_last && b_full)) begin
                    if (state_q == Write && w_head.strb != '0) begin
                        way_valid = 1'b1;
                        consume   = bus.way_inp_ready_i;
                    end else begin
                        consume   = 1'b1;
                    end
                end
                if (consume) begin
                    w_pop = 1'b1;
                    if (last_beat) begin
                        unlock_req = 1'b1;
                        b_push     = desc_q.x_last;
                        state_d    = Idle;
                        load       = ~desc_empty;
                    end else begin
                        desc_d.a_x_len  = desc_q.a_x_len - LenW'(1);
                        desc_d.a_x_addr = next_addr(desc_q, mask_q);
                    end
                end
            end
            default: state_d = Idle;
        endcase

        if (load) begin
            desc_pop = 1'b1;
            desc_d   = desc_head;
            mask_d   = (AddrW'(desc_head.a_x_len) + AddrW'(1)) * num_bytes(desc_head.a_x_size)
                       - AddrW'(1);
            state_d  = (desc_head.x_resp == RespSlvErr) ? Drop : Write;
        end
    end

    // FSM state, active descriptor and wrap mask.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Idle;
            desc_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            mask_q  <= mask_d;
        end
    end
endmodule

// File: tb/tb_axi_llc_write_unit_queued.sv
// Directed bench for the queued LLC write unit.
module tb_axi_llc_write_unit_queued;
    import axi_llc_write_unit_queued_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic test;
    logic busy;
    int unsigned cyc = 0;
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    axi_llc_write_unit_queued_if bus ();

    axi_llc_write_unit_queued dut (
        .clk_i (clk),
        .rst_i (rst),
        .test_i(test),
        .bus   (bus.slave),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    desc_t       dq[$];
    w_chan_t     wq[$];
    bit          d_acc, w_acc, way_seen;
    way_inp_t    way_log[$];
    int unsigned way_cyc[$];
    lock_t       unl_log[$];
    int unsigned unl_cyc[$];
    b_chan_t     b_log[$];
    int unsigned b_cyc[$];

    function automatic desc_t mk_desc(input logic [3:0] id, input logic [31:0] addr,
                                      input logic [7:0] len, input logic [1:0] burst,
                                      input logic [1:0] resp, input logic [2:0] way);
        desc_t d;
        d.a_x_id = id; d.a_x_addr = addr; d.a_x_len = len; d.a_x_size = 3'd3;
        d.a_x_burst = burst; d.x_resp = resp; d.x_last = 1'b1; d.way_ind = way;
        return d;
    endfunction

    function automatic w_chan_t mk_w(input logic [63:0] data, input logic [7:0] strb);
        w_chan_t w;
        w.data = data; w.strb = strb;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic clr();
        way_log.delete(); way_cyc.delete(); unl_log.delete(); unl_cyc.delete();
        b_log.delete(); b_cyc.delete(); way_seen = 1'b0;
    endtask

    task automatic wait_b(input int n, input int budget, input string tag);
        int k = 0;
        while (b_log.size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 64'(b_log.size()), 64'(n));
    endtask

    // Stream drivers: present queue heads, retire them after an observed handshake.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (d_acc && dq.size() != 0) void'(dq.pop_front());
            if (w_acc && wq.size() != 0) void'(wq.pop_front());
            d_acc = 1'b0;
            w_acc = 1'b0;
            bus.desc_valid_i   = (dq.size() != 0);
            bus.desc_i         = (dq.size() != 0) ? dq[0] : '0;
            bus.w_chan_valid_i = (wq.size() != 0);
            bus.w_chan_slv_i   = (wq.size() != 0) ? wq[0] : '0;
        end
    end

    // Monitor: record handshakes on the falling edge, stamped with the cycle count.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                d_acc = 1'b0;
                w_acc = 1'b0;
            end else begin
                d_acc = bus.desc_valid_i && bus.desc_ready_o;
                w_acc = bus.w_chan_valid_i && bus.w_chan_ready_o;
                if (bus.way_inp_valid_o) way_seen = 1'b1;
                if (bus.way_inp_valid_o && bus.way_inp_ready_i) begin
                    way_log.push_back(bus.way_inp_o);
                    way_cyc.push_back(cyc);
                end
                if (bus.w_unlock_req_o) begin
                    unl_log.push_back(bus.w_unlock_o);
                    unl_cyc.push_back(cyc);
                end
                if (bus.b_chan_valid_o && bus.b_chan_ready_i) begin
                    b_log.push_back(bus.b_chan_slv_o);
                    b_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1; test = 1'b0;
        bus.desc_valid_i = 1'b0; bus.desc_i = '0;
        bus.w_chan_valid_i = 1'b0; bus.w_chan_slv_i = '0;
        bus.b_chan_ready_i = 1'b1; bus.way_inp_ready_i = 1'b1; bus.w_unlock_gnt_i = 1'b1;
        clr();

        // Reset state
        step(2);
        chk("rst_way_valid", 64'(bus.way_inp_valid_o), 64'd0);
        chk("rst_b_valid", 64'(bus.b_chan_valid_o), 64'd0);
        chk("rst_unlock", 64'(bus.w_unlock_req_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step(1);
        chk("rst_desc_ready", 64'(bus.desc_ready_o), 64'd1);
        chk("rst_w_ready", 64'(bus.w_chan_ready_o), 64'd1);

        // INCR burst at 0x40, four beats
        clr();
        dq.push_back(mk_desc(4'd5, 32'h40, 8'd3, BurstIncr, RespOkay, 3'd2));
        for (int i = 0; i < 4; i++) wq.push_back(mk_w(64'h1000 + 64'(i), 8'hff));
        wait_b(1, 60, "incr_b_count");
        chk("incr_way_count", 64'(way_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("incr_off%0d", i), 64'(way_log[i].blk_offset), 64'(i));
        chk("incr_index", 64'(way_log[0].line_addr), 64'd1);
        chk("incr_data2", way_log[2].data, 64'h1002);
        chk("incr_we_unit_way", 64'({way_log[1].we, way_log[1].cache_unit, way_log[1].way_ind}),
            64'({1'b1, 2'd2, 3'd2}));
        chk("incr_unl_count", 64'(unl_log.size()), 64'd1);
        chk("incr_unl_cycle", 64'(unl_cyc[0]), 64'(way_cyc[3]));
        chk("incr_unl_payload", 64'({unl_log[0].index, unl_log[0].way_ind}), 64'({8'd1, 3'd2}));
        chk("incr_b_id_resp", 64'({b_log[0].id, b_log[0].resp}), 64'({4'd5, 2'b00}));
        chk("incr_b_latency", 64'(b_cyc[0]), 64'(unl_cyc[0] + 1));
        step(2);
        chk("incr_idle", 64'(busy), 64'd0);

        // WRAP burst starting at 0x58
        clr();
        dq.push_back(mk_desc(4'd6, 32'h58, 8'd3, BurstWrap, RespOkay, 3'd0));
        for (int i = 0; i < 4; i++) wq.push_back(mk_w(64'h2000 + 64'(i), 8'hff));
        wait_b(1, 60, "wrap_b_count");
        chk("wrap_way_count", 64'(way_log.size()), 64'd4);
        chk("wrap_off0", 64'(way_log[0].blk_offset), 64'd3);
        chk("wrap_off1", 64'(way_log[1].blk_offset), 64'd0);
        chk("wrap_off2", 64'(way_log[2].blk_offset), 64'd1);
        chk("wrap_off3", 64'(way_log[3].blk_offset), 64'd2);
        chk("wrap_index3", 64'(way_log[3].line_addr), 64'd1);

        // SLVERR descriptor: beats dropped
        clr();
        dq.push_back(mk_desc(4'd3, 32'h80, 8'd1, BurstIncr, RespSlvErr, 3'd1));
        for (int i = 0; i < 2; i++) wq.push_back(mk_w(64'h3000 + 64'(i), 8'hff));
        wait_b(1, 60, "drop_b_count");
        chk("drop_way_never", 64'(way_seen), 64'd0);
        chk("drop_unl_count", 64'(unl_log.size()), 64'd1);
        chk("drop_b_id_resp", 64'({b_log[0].id, b_log[0].resp}), 64'({4'd3, 2'b10}));
        step(2);
        chk("drop_drained", 64'(busy), 64'd0);

        // Zero-strobe beat skipped without a way request
        clr();
        dq.push_back(mk_desc(4'd1, 32'h40, 8'd2, BurstIncr, RespOkay, 3'd0));
        wq.push_back(mk_w(64'h4000, 8'hff));
        wq.push_back(mk_w(64'h4001, 8'h00));
        wq.push_back(mk_w(64'h4002, 8'h0f));
        wait_b(1, 60, "strb0_b_count");
        chk("strb0_way_count", 64'(way_log.size()), 64'd2);
        chk("strb0_off1", 64'(way_log[1].blk_offset), 64'd2);
        chk("strb0_strb1", 64'(way_log[1].strb), 64'h0f);

        // Back-to-back descriptors without a bubble
        clr();
        dq.push_back(mk_desc(4'd6, 32'h100, 8'd3, BurstIncr, RespOkay, 3'd0));
        dq.push_back(mk_desc(4'd7, 32'h200, 8'd3, BurstIncr, RespOkay, 3'd1));
        for (int i = 0; i < 8; i++) wq.push_back(mk_w(64'h5000 + 64'(i), 8'hff));
        wait_b(2, 80, "b2b_b_count");
        chk("b2b_way_count", 64'(way_log.size()), 64'd8);
        chk("b2b_no_bubble", 64'(way_cyc[4] - way_cyc[3]), 64'd1);
        chk("b2b_span", 64'(way_cyc[7] - way_cyc[0]), 64'd7);
        chk("b2b_index2", 64'(way_log[4].line_addr), 64'd8);
        chk("b2b_b_order", 64'({b_log[0].id, b_log[1].id}), 64'({4'd6, 4'd7}));

        // B back-pressure stalls the third single-beat burst
        clr();
        bus.b_chan_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            dq.push_back(mk_desc(4'(i), 32'h0, 8'd0, BurstIncr, RespOkay, 3'd0));
            wq.push_back(mk_w(64'h6000 + 64'(i), 8'hff));
        end
        step(30);
        chk("bp_b_valid", 64'(bus.b_chan_valid_o), 64'd1);
        chk("bp_unl_count", 64'(unl_log.size()), 64'd2);
        chk("bp_way_count", 64'(way_log.size()), 64'd2);
        chk("bp_busy", 64'(busy), 64'd1);
        bus.b_chan_ready_i = 1'b1;
        wait_b(3, 40, "bp_b_count");
        chk("bp_b_order", 64'({b_log[0].id, b_log[1].id, b_log[2].id}), 64'({4'd1, 4'd2, 4'd3}));
        chk("bp_unl_final", 64'(unl_log.size()), 64'd3);
        chk("bp_stall_until_b", 64'(unl_cyc[2] > b_cyc[0]), 64'd1);

        // Unlock grant low blocks all beat processing
        clr();
        bus.w_unlock_gnt_i = 1'b0;
        dq.push_back(mk_desc(4'd4, 32'h40, 8'd3, BurstIncr, RespOkay, 3'd0));
        for (int i = 0; i < 4; i++) wq.push_back(mk_w(64'h7000 + 64'(i), 8'hff));
        step(20);
        chk("gnt0_w_full", 64'(bus.w_chan_ready_o), 64'd0);
        chk("gnt0_way_never", 64'(way_seen), 64'd0);
        chk("gnt0_unl_none", 64'(unl_log.size()), 64'd0);
        bus.w_unlock_gnt_i = 1'b1;
        wait_b(1, 60, "gnt1_b_count");
        chk("gnt1_way_count", 64'(way_log.size()), 64'd4);

        // Reset in the middle of an eight-beat burst
        clr();
        dq.push_back(mk_desc(4'd2, 32'h0, 8'd7, BurstIncr, RespOkay, 3'd0));
        for (int i = 0; i < 3; i++) wq.push_back(mk_w(64'h8000 + 64'(i), 8'hff));
        k = 0;
        while (way_log.size() < 3 && k < 40) begin
            step(1);
            k++;
        end
        chk("mid_beats", 64'(way_log.size()), 64'd3);
        bus.way_inp_ready_i = 1'b0;
        wq.push_back(mk_w(64'h8003, 8'hff));
        step(3);
        chk("mid_way_pending", 64'(bus.way_inp_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_way_valid", 64'(bus.way_inp_valid_o), 64'd0);
        chk("mid_rst_b_valid", 64'(bus.b_chan_valid_o), 64'd0);
        chk("mid_rst_unlock", 64'(bus.w_unlock_req_o), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        step(2);
        bus.way_inp_ready_i = 1'b1;
        rst = 1'b0;
        clr();
        step(1);
        dq.push_back(mk_desc(4'd9, 32'h80, 8'd0, BurstIncr, RespOkay, 3'd0));
        wq.push_back(mk_w(64'h9000, 8'hff));
        wait_b(1, 40, "post_rst_b_count");
        chk("post_rst_way_count", 64'(way_log.size()), 64'd1);
        chk("post_rst_addr", 64'({way_log[0].line_addr, way_log[0].blk_offset}), 64'({8'd2, 3'd0}));
        chk("post_rst_data", way_log[0].data, 64'h9000);
        chk("post_rst_b", 64'({b_log[0].id, b_log[0].resp}), 64'({4'd9, 2'b00}));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
